// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache refill path.
package dcache_pkg;

  localparam int LINE_WORDS = 16;
  localparam int WORD_W     = 32;
  localparam int OFFSET_W   = 6;
  localparam int INDEX_W    = 8;
  localparam int TAG_W      = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

endpackage

// File: rtl/refill_line_buf.sv
// Line-wide word register: bulk load of a victim line, single-word writes during
// refill, one indexed read port for writeback data, and the full line out.
module refill_line_buf #(
  parameter int LINE_WORDS = 16,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_i,
  input  logic [LINE_WORDS-1:0][DATA_W-1:0] line_i,
  input  logic                              we_i,
  input  logic [IDX_W-1:0]                  idx_i,
  input  logic [DATA_W-1:0]                 wdata_i,
  output logic [DATA_W-1:0]                 rword_o,
  output logic [LINE_WORDS-1:0][DATA_W-1:0] line_o
);

  logic [LINE_WORDS-1:0][DATA_W-1:0] words_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        words_q <= '0;
    else if (load_i) words_q <= line_i;
    else if (we_i)   words_q[idx_i] <= wdata_i;
  end

  assign rword_o = words_q[idx_i];
  assign line_o  = words_q;

endmodule

// File: rtl/dcache_refill_ctl.sv
// Miss/eviction controller: writes back a dirty victim word by word, then reads
// the missing line word by word and returns it with a one-cycle response pulse.
module dcache_refill_ctl #(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cache_miss,
  input  logic [ADDR_W-1:0]            i_miss_addr,
  input  logic                         i_evict,
  input  logic [ADDR_W-1:0]            i_evict_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] i_evict_data,
  output logic                         o_stall,
  output logic [LINE_WORDS*DATA_W-1:0] o_memory_line,
  output logic                         o_memory_response,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [DATA_W-1:0]            o_mem_wdata,
  input  logic                         i_mem_ack,
  input  logic [DATA_W-1:0]            i_mem_rdata
);

  import dcache_pkg::*;

  localparam int                 CNT_W     = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0]   LAST      = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0]  BASE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [ADDR_W-1:0]                 miss_base_q, miss_base_d;
  logic [ADDR_W-1:0]                 evict_base_q, evict_base_d;
  logic                              buf_load, buf_we;
  logic [DATA_W-1:0]                 buf_rword;
  logic [LINE_WORDS-1:0][DATA_W-1:0] evict_line, buf_line;
  logic [ADDR_W-1:0]                 word_off;

  assign evict_line    = i_evict_data;
  assign o_memory_line = buf_line;
  assign word_off      = ADDR_W'({cnt_q, 2'b00});
  assign o_stall       = i_cache_miss | (state_q != IDLE);

  refill_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .DATA_W     (DATA_W)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .line_i  (evict_line),
    .we_i    (buf_we),
    .idx_i   (cnt_q),
    .wdata_i (i_mem_rdata),
    .rword_o (buf_rword),
    .line_o  (buf_line)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_base_q  <= '0;
      evict_base_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_base_q  <= miss_base_d;
      evict_base_q <= evict_base_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    miss_base_d       = miss_base_q;
    evict_base_d      = evict_base_q;
    buf_load          = 1'b0;
    buf_we            = 1'b0;
    o_mem_req         = 1'b0;
    o_mem_we          = 1'b0;
    o_mem_addr        = '0;
    o_mem_wdata       = '0;
    o_memory_response = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_cache_miss) begin
          miss_base_d  = i_miss_addr & BASE_MASK;
          evict_base_d = i_evict_addr & BASE_MASK;
          // Victim data only matters for a dirty eviction; a clean miss leaves
          // the previous line visible until read data overwrites it.
          buf_load     = i_evict;
          cnt_d        = '0;
          state_d      = i_evict ? WB : RD;
        end
      end
      WB: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = evict_base_q + word_off;
        o_mem_wdata = buf_rword;
        if (i_mem_ack) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = RD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RD: begin
        o_mem_req  = 1'b1;
        o_mem_addr = miss_base_q + word_off;
        if (i_mem_ack) begin
          buf_we = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP: begin
        o_memory_response = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_refill_ctl.sv
// Randomized scoreboard bench for dcache_refill_ctl with a word-addressed memory model.
module tb_dcache_refill_ctl;

  localparam int LW = 16;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                i_cache_miss = 1'b0;
  logic [AW-1:0]       i_miss_addr = '0;
  logic                i_evict = 1'b0;
  logic [AW-1:0]       i_evict_addr = '0;
  logic [LW*DW-1:0]    i_evict_data = '0;
  logic                o_stall;
  logic [LW*DW-1:0]    o_memory_line;
  logic                o_memory_response;
  logic                o_mem_req;
  logic                o_mem_we;
  logic [AW-1:0]       o_mem_addr;
  logic [DW-1:0]       o_mem_wdata;
  logic                i_mem_ack = 1'b0;
  logic [DW-1:0]       i_mem_rdata = '0;

  dcache_refill_ctl #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_cache_miss      (i_cache_miss),
    .i_miss_addr       (i_miss_addr),
    .i_evict           (i_evict),
    .i_evict_addr      (i_evict_addr),
    .i_evict_data      (i_evict_data),
    .o_stall           (o_stall),
    .o_memory_line     (o_memory_line),
    .o_memory_response (o_memory_response),
    .o_mem_req         (o_mem_req),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .i_mem_ack         (i_mem_ack),
    .i_mem_rdata       (i_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mreq_t;

  mreq_t              exp_q[$];
  dcache_pkg::line_t  resp_q[$];
  logic [31:0]        ref_mem  [logic [31:0]];
  logic [31:0]        phys_mem [logic [31:0]];
  int                 checks = 0;
  int                 errors = 0;
  int                 ack_mode = 0;  // 0: ack tied high, 1: random 0-3 wait states

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference: a miss is a line writeback (if dirty) followed by a line read,
  // ascending word order, against a flat memory.
  task automatic plan(input logic [31:0] maddr, input logic ev, input logic [31:0] eaddr,
                      input dcache_pkg::line_t edata);
    logic [31:0]       mb, eb, a;
    dcache_pkg::line_t line;
    mb = {maddr[31:6], 6'd0};
    eb = {eaddr[31:6], 6'd0};
    if (ev) begin
      for (int k = 0; k < LW; k++) begin
        a = eb + 32'(4 * k);
        exp_q.push_back('{1'b1, a, edata[k]});
        ref_mem[a] = edata[k];
      end
    end
    for (int k = 0; k < LW; k++) begin
      a = mb + 32'(4 * k);
      exp_q.push_back('{1'b0, a, 32'h0});
      line[k] = ref_rd(a);
    end
    resp_q.push_back(line);
  endtask

  // Memory responder and request monitor.
  logic        pend = 1'b0;
  int          wait_n = 0;
  logic [31:0] s_addr, s_wd;
  logic        s_we;
  always @(negedge clk) begin
    mreq_t e;
    if (!rst) begin
      pend = 1'b0;
      i_mem_ack = 1'b0;
    end else if (o_mem_req) begin
      if (pend) begin
        chk("hold_addr", o_mem_addr, s_addr);
        chk("hold_wdata", o_mem_wdata, s_wd);
        chk("hold_we", o_mem_we, s_we);
      end else begin
        pend   = 1'b1;
        s_addr = o_mem_addr;
        s_wd   = o_mem_wdata;
        s_we   = o_mem_we;
        wait_n = (ack_mode == 0) ? 0 : int'($urandom_range(0, 3));
      end
      if (wait_n == 0) begin
        i_mem_ack = 1'b1;
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_req act=%0h exp=none", o_mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("mem_we", o_mem_we, e.we);
          chk("mem_addr", o_mem_addr, e.addr);
          if (e.we) chk("mem_wdata", o_mem_wdata, e.data);
        end
        if (o_mem_we) begin
          phys_mem[o_mem_addr] = o_mem_wdata;
          i_mem_rdata = $urandom;
        end else begin
          i_mem_rdata = phys_rd(o_mem_addr);
        end
      end else begin
        i_mem_ack = 1'b0;
        wait_n--;
        i_mem_rdata = $urandom;
      end
    end else begin
      pend = 1'b0;
      i_mem_ack = (ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      i_mem_rdata = $urandom;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst && o_memory_response) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_resp act=%0h exp=none", o_memory_line);
      end else begin
        chk("line", o_memory_line, resp_q.pop_front());
      end
    end
  end

  task automatic do_miss(input logic [31:0] maddr, input logic ev, input logic [31:0] eaddr,
                         input dcache_pkg::line_t edata, input int lat, input logic glitch);
    int   cyc;
    logic done;
    plan(maddr, ev, eaddr, edata);
    @(negedge clk);
    i_miss_addr  = maddr;
    i_evict      = ev;
    i_evict_addr = eaddr;
    i_evict_data = edata;
    i_cache_miss = 1'b1;
    #1 chk("stall_miss_cycle", o_stall, 1);
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (o_memory_response) done = 1'b1;
      else chk("stall_busy", o_stall, 1);
      if (glitch && cyc == 5) begin
        i_cache_miss = 1'b0;
        i_miss_addr  = maddr ^ 32'h0001_0040;
        i_evict      = ~ev;
      end
      if (glitch && cyc == 6) i_cache_miss = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout act=%0d exp=response", cyc);
    end else if (lat > 0) begin
      chk("latency", cyc, lat);
    end
    i_cache_miss = 1'b0;
    i_evict      = 1'b0;
    @(negedge clk);
    chk("stall_after", o_stall, 0);
    chk("resp_one_cycle", o_memory_response, 0);
  endtask

  task automatic reset_mid_read(input logic [31:0] maddr);
    logic [31:0] mb;
    logic        found;
    mb = {maddr[31:6], 6'd0};
    plan(maddr, 1'b0, 32'h0, '0);
    @(negedge clk);
    i_miss_addr  = maddr;
    i_evict      = 1'b0;
    i_cache_miss = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (o_mem_req && !o_mem_we && o_mem_addr == mb + 32'd28) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL word7_timeout act=none exp=%0h", mb + 32'd28);
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_req", o_mem_req, 0);
    chk("rst_addr", o_mem_addr, 0);
    i_cache_miss = 1'b0;
    exp_q.delete();
    resp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_resp", o_memory_response, 0);
    end
    rst = 1'b1;
  endtask

  initial begin
    dcache_pkg::line_t ed;
    logic [31:0]       ma, ea;
    logic              ev;

    #3;
    chk("rst_req0", o_mem_req, 0);
    chk("rst_we0", o_mem_we, 0);
    chk("rst_addr0", o_mem_addr, 0);
    chk("rst_wdata0", o_mem_wdata, 0);
    chk("rst_resp0", o_memory_response, 0);
    chk("rst_line0", o_memory_line, 0);
    chk("rst_stall0", o_stall, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_spurious_ack_req", o_mem_req, 0);

    ack_mode = 0;
    do_miss(32'h0000_1234, 1'b0, 32'h0, '0, 18, 1'b0);

    for (int k = 0; k < LW; k++) ed[k] = 32'hA000_0000 + 32'(k);
    do_miss(32'h0000_0080, 1'b1, 32'h0000_8040, ed, 34, 1'b0);

    ack_mode = 1;
    for (int n = 0; n < 8; n++) begin
      ma = $urandom;
      ea = $urandom;
      ev = 1'($urandom_range(0, 1));
      if (n == 3) begin ea = ma ^ 32'h15; ev = 1'b1; end
      if (n == 5) begin ma = 32'hFFFF_FFF0; ea = 32'hFFFF_FFC4; ev = 1'b1; end
      for (int k = 0; k < LW; k++) ed[k] = $urandom;
      do_miss(ma, ev, ea, ed, 0, 1'b0);
    end

    for (int k = 0; k < LW; k++) ed[k] = $urandom;
    do_miss(32'h0004_2000, 1'b1, 32'h0007_7740, ed, 0, 1'b1);

    ack_mode = 0;
    reset_mid_read(32'h0000_3300);
    do_miss(32'h0000_3300, 1'b0, 32'h0, '0, 18, 1'b0);

    repeat (2) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_refill_ctl.md
Name: dcache_refill_ctl

Overview:
- Miss/eviction controller that sits directly downstream of the set-associative data cache (sa_cache).
- Takes a cache miss (plus an optional dirty-victim eviction), writes the victim line back to backing memory one word at a time, then reads the missing line the same way.
- Returns the assembled line to the cache with a one-cycle response pulse.
- Stalls the pipeline while busy.

Parameters:
- LINE_WORDS, 16, 32-bit words per cache line (64-byte line, 6-bit offset)
- ADDR_W, 32, byte address width
- DATA_W, 32, backing-memory bus width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- i_cache_miss  in  1  cache reports a miss; held by the cache until o_memory_response
- i_miss_addr  in  ADDR_W  byte address that missed
- i_evict  in  1  victim line is dirty; valid with i_cache_miss
- i_evict_addr  in  ADDR_W  victim line address
- i_evict_data  in  LINE_WORDS*DATA_W  victim line contents, word 0 in bits [31:0]
- o_stall  out  1  pipeline stall request
- o_memory_line  out  LINE_WORDS*DATA_W  refilled line, word 0 in bits [31:0]
- o_memory_response  out  1  one-cycle pulse; o_memory_line is valid this cycle
- o_mem_req  out  1  backing-memory request
- o_mem_we  out  1  1 = write, 0 = read
- o_mem_addr  out  ADDR_W  word-aligned memory address
- o_mem_wdata  out  DATA_W  write data
- i_mem_ack  in  1  memory accepts/completes the current request this cycle
- i_mem_rdata  in  DATA_W  read data, valid when i_mem_ack=1 and o_mem_we=0

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; word counter = 0.
  - Outputs: o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_memory_response=0, o_memory_line=0.
  - Reset mid-transfer abandons the transfer; no response is issued.
- FSM states: IDLE, WB, RD, RESP.
  - IDLE: if i_cache_miss=1, capture the line bases (addr[5:0] forced to 0) and i_evict_data.
    - Next state is WB if i_evict=1, else RD.
    - o_mem_req rises the next cycle (registered).
  - WB: o_mem_req=1, o_mem_we=1, o_mem_addr = evict_base + 4*cnt, o_mem_wdata = captured word[cnt].
    - Each i_mem_ack increments cnt.
    - On the ack with cnt=LINE_WORDS-1: cnt wraps to 0, state goes to RD, req stays high with we=0.
  - RD: o_mem_req=1, o_mem_we=0, o_mem_addr = miss_base + 4*cnt.
    - On ack, i_mem_rdata is stored to line word[cnt] and cnt increments.
    - On the ack with cnt=LINE_WORDS-1: cnt goes to 0, state goes to RESP, o_mem_req drops.
  - RESP: o_memory_response=1 for exactly one cycle; o_memory_line holds the assembled line; next state is IDLE.
- Word order is ascending; there is no critical-word-first.
- Handshake:
  - o_mem_req, o_mem_addr and o_mem_wdata stay stable until acked.
  - A zero-wait memory may ack in the same cycle req is high.
  - i_mem_ack while o_mem_req=0 is ignored.
- o_stall = i_cache_miss | (state != IDLE). It is combinational so the miss cycle itself stalls; it drops the cycle after RESP.
- o_memory_line holds its value until the next refill overwrites words.
- Latency with ack tied high:
  - Clean miss: 16 RD cycles; response in the 18th cycle after the miss is accepted (accept, 16 RD, RESP).
  - Dirty miss: 16 extra cycles.
- Boundary conditions:
  - i_cache_miss while not IDLE is ignored; the cache holds its request.
  - i_evict is ignored unless i_cache_miss=1 in IDLE.
  - evict_base == miss_base: writeback still precedes the read, so the read returns the written data.
  - Address arithmetic is modulo 2^ADDR_W.
  - i_cache_miss deasserting mid-transfer does not abort the transfer.

Decomposition:
- Package dcache_pkg holds: LINE_WORDS, OFFSET_W=6, INDEX_W=8, TAG_W=18, the state enum {IDLE, WB, RD, RESP}, and the line_t typedef.
- Sub-module refill_line_buf: LINE_WORDS x DATA_W register with word write-enable/index and full-line output, shared by the capture and assembly paths.

Test Plan:
- Clean miss at 0x0000_1234, ack tied 1 -> reads at 0x1200..0x123C ascending, we=0; response pulse in cycle 18; line = memory words 0x1200..0x123C.
- Dirty miss: evict_addr 0x0000_8040 with data word k = 0xA000_0000+k; miss 0x0000_0080 -> 16 writes 0x8040..0x807C carrying 0xA0000000..0xA000000F, then 16 reads from 0x80; single response pulse.
- Random ack stalls of 0-3 cycles -> addr/wdata stable while req is high and unacked; line correct; o_stall high throughout, low the cycle after RESP.
- Reset asserted during RD word 7 -> req=0 immediately, no response; a new miss afterwards starts at word 0.
- Second i_cache_miss pulse with a different address during WB, plus a spurious ack while idle -> both ignored; the transfer proceeds for the original address.
